// File: rtl/gate_pkg.sv
// Shared encodings for the garage gate arbiter: FSM states, direction codes
// (which double as the moving[1:0] output codes) and the phase counter width.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    PASSING = 2'd2,
    CLOSING = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_IN = 2'b01,
    DIR_EX = 2'b10
  } dir_e;

  localparam logic [1:0] MOVE_IDLE = 2'b00;

  localparam int unsigned TICK_W = 8;

endpackage

// File: rtl/gate_arbiter_if.sv
// Request/status bundle between the button front end, the gate arbiter and
// the display/full-LED consumers.
interface gate_arbiter_if;
  logic       tick;
  logic       entry_req;
  logic       exit_req;
  logic [3:0] remain;
  logic [1:0] moving;
  logic       gate_open;
  logic       full;
  logic       reject;
  logic       busy;

  modport master (
    output tick, entry_req, exit_req,
    input  remain, moving, gate_open, full, reject, busy
  );

  modport slave (
    input  tick, entry_req, exit_req,
    output remain, moving, gate_open, full, reject, busy
  );
endinterface

// File: rtl/gate_arbiter_phase_timer.sv
// Tick-gated phase counter. done fires on the tick that completes the phase
// (counter == last) and the counter wraps to zero on that same edge.
module phase_timer
  import gate_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic              tick,
  input  logic [TICK_W-1:0] last,
  output logic              done
);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign done = en && tick && (cnt_q == last);

  // Next count: clear dominates, otherwise advance on tick and wrap at last.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && tick) begin
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gate_arbiter.sv
// Garage gate arbiter: latches one pending request per direction, grants the
// gate, walks it through OPENING/PASSING/CLOSING and owns the free-space count.
// Optional macro GATE_ARB_FAIR_RR_EN selects round-robin arbitration when both
// directions are pending; otherwise exit always wins.
module gate_arbiter
  import gate_pkg::*;
#(
  parameter int unsigned CAPACITY    = 9,
  parameter int unsigned OPEN_TICKS  = 2,
  parameter int unsigned PASS_TICKS  = 3,
  parameter int unsigned CLOSE_TICKS = 2
) (
  input logic          clk,
  input logic          rst_n,
  gate_arbiter_if.slave bus
);

  localparam logic [3:0] CAP = 4'(CAPACITY);

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  dir_e              last_dir_q, last_dir_d;
  logic              pend_in_q, pend_in_d;
  logic              pend_ex_q, pend_ex_d;
  logic [3:0]        remain_q, remain_d;
  logic              reject_q, reject_d;

  logic              full;
  logic              pin, pex;
  logic              in_bad, ex_bad;
  logic              grant_in;
  logic              clear;
  logic              done;
  logic [TICK_W-1:0] last_sel;

  assign full = (remain_q == '0);

  // A request pulse in the same cycle counts toward the grant decision so an
  // idle gate reacts one cycle after the pulse; refused entries never latch.
  assign pin    = pend_in_q | (bus.entry_req & ~full);
  assign pex    = pend_ex_q | bus.exit_req;
  assign in_bad = pin && (remain_q == '0);
  assign ex_bad = pex && (remain_q == CAP);

`ifdef GATE_ARB_FAIR_RR_EN
  assign grant_in = pin && (!pex || (last_dir_q == DIR_EX));
`else
  assign grant_in = pin && !pex;
`endif

  // Phase length for the current state.
  always_comb begin
    last_sel = '0;
    case (state_q)
      OPENING: last_sel = TICK_W'(OPEN_TICKS - 1);
      PASSING: last_sel = TICK_W'(PASS_TICKS - 1);
      CLOSING: last_sel = TICK_W'(CLOSE_TICKS - 1);
      default: last_sel = '0;
    endcase
  end

  phase_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .en    (state_q != IDLE),
    .tick  (bus.tick),
    .last  (last_sel),
    .done  (done)
  );

  // Next-state, pending latches, grant arbitration and space count.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    pend_in_d  = pin;
    pend_ex_d  = pex;
    remain_d   = remain_q;
    reject_d   = bus.entry_req && full && !pend_in_q;
    clear      = 1'b0;
    case (state_q)
      IDLE: begin
        clear = 1'b1;
        // Stale requests are dropped first; any drop suppresses the grant.
        if (in_bad) begin
          pend_in_d = 1'b0;
          reject_d  = 1'b1;
        end
        if (ex_bad) begin
          pend_ex_d = 1'b0;
        end
        if ((pin || pex) && !in_bad && !ex_bad) begin
          if (grant_in) begin
            pend_in_d  = 1'b0;
            dir_d      = DIR_IN;
            last_dir_d = DIR_IN;
          end else begin
            pend_ex_d  = 1'b0;
            dir_d      = DIR_EX;
            last_dir_d = DIR_EX;
          end
          state_d = OPENING;
        end
      end
      OPENING: if (done) state_d = PASSING;
      PASSING: begin
        if (done) begin
          state_d = CLOSING;
          if (dir_q == DIR_IN) begin
            if (remain_q != '0) remain_d = remain_q - 1'b1;
          end else begin
            if (remain_q != CAP) remain_d = remain_q + 1'b1;
          end
        end
      end
      CLOSING: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= DIR_EX;
      last_dir_q <= DIR_EX;
      pend_in_q  <= 1'b0;
      pend_ex_q  <= 1'b0;
      remain_q   <= CAP;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      pend_in_q  <= pend_in_d;
      pend_ex_q  <= pend_ex_d;
      remain_q   <= remain_d;
      reject_q   <= reject_d;
    end
  end

  assign bus.remain    = remain_q;
  assign bus.full      = full;
  assign bus.reject    = reject_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gate_open = (state_q == PASSING);
  assign bus.moving    = (state_q == IDLE) ? MOVE_IDLE : dir_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed bench for gate_arbiter with default parameters; tick every 4 cycles.
module tb_gate_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_arbiter_if bus ();

  gate_arbiter #(
    .CAPACITY    (9),
    .OPEN_TICKS  (2),
    .PASS_TICKS  (3),
    .CLOSE_TICKS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   tcnt  = 0;
  logic tick_en = 1'b0;
  logic last_tick = 1'b0;

`ifdef GATE_ARB_FAIR_RR_EN
  localparam logic [7:0] FIRST_MOVE  = 8'd1;
  localparam logic [7:0] FIRST_RMN   = 8'd4;
  localparam logic [7:0] SECOND_MOVE = 8'd2;
`else
  localparam logic [7:0] FIRST_MOVE  = 8'd2;
  localparam logic [7:0] FIRST_RMN   = 8'd6;
  localparam logic [7:0] SECOND_MOVE = 8'd1;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ein, input logic eex);
    bus.entry_req = ein;
    bus.exit_req  = eex;
    last_tick     = tick_en && (tcnt == 3);
    bus.tick      = last_tick;
    tcnt          = (tcnt + 1) % 4;
    @(posedge clk);
    #1;
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    bus.tick      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk(tag, 8'(bus.busy), 8'd0);
  endtask

  task automatic run_seq(input logic ein, input logic eex, input string tag);
    step(ein, eex);
    wait_idle(tag, 100);
  endtask

  task automatic wait_open(input string tag);
    int n = 0;
    while (!bus.gate_open && n < 100) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk(tag, 8'(bus.gate_open), 8'd1);
  endtask

  initial begin
    int   n, busy_ticks, open_ticks, rises;
    logic pb, po;

    bus.tick = 1'b0; bus.entry_req = 1'b0; bus.exit_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_remain", 8'(bus.remain), 8'd9);
    chk("rst_moving", 8'(bus.moving), 8'd0);
    chk("rst_gate_open", 8'(bus.gate_open), 8'd0);
    chk("rst_full", 8'(bus.full), 8'd0);
    chk("rst_reject", 8'(bus.reject), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    rst_n   = 1'b1;
    tick_en = 1'b1;

    // Single entry, full phase walk.
    step(1'b1, 1'b0);
    chk("t1_busy", 8'(bus.busy), 8'd1);
    chk("t1_moving", 8'(bus.moving), 8'd1);
    chk("t1_remain_pre", 8'(bus.remain), 8'd9);
    busy_ticks = 0; open_ticks = 0; n = 0;
    while (bus.busy && n < 100) begin
      pb = bus.busy; po = bus.gate_open;
      step(1'b0, 1'b0);
      n++;
      if (last_tick && pb) busy_ticks++;
      if (last_tick && po) open_ticks++;
      if (po && !bus.gate_open) begin
        chk("t1_remain_post_pass", 8'(bus.remain), 8'd8);
        chk("t1_moving_closing", 8'(bus.moving), 8'd1);
      end
    end
    chk("t1_idle", 8'(bus.busy), 8'd0);
    chk("t1_busy_ticks", 8'(busy_ticks), 8'd7);
    chk("t1_open_ticks", 8'(open_ticks), 8'd3);
    chk("t1_moving_idle", 8'(bus.moving), 8'd0);

    // Fill to full, then a refused entry.
    for (int i = 0; i < 8; i++) run_seq(1'b1, 1'b0, "t2_fill_idle");
    chk("t2_remain0", 8'(bus.remain), 8'd0);
    chk("t2_full", 8'(bus.full), 8'd1);
    step(1'b1, 1'b0);
    chk("t2_reject_hi", 8'(bus.reject), 8'd1);
    chk("t2_busy_lo", 8'(bus.busy), 8'd0);
    step(1'b0, 1'b0);
    chk("t2_reject_1cyc", 8'(bus.reject), 8'd0);
    repeat (3) step(1'b0, 1'b0);
    chk("t2_no_pend_reject", 8'(bus.reject), 8'd0);
    chk("t2_no_pend_busy", 8'(bus.busy), 8'd0);
    chk("t2_remain_hold", 8'(bus.remain), 8'd0);

    // Simultaneous requests at remain=5.
    for (int i = 0; i < 5; i++) run_seq(1'b0, 1'b1, "t3_drain_idle");
    chk("t3_remain5", 8'(bus.remain), 8'd5);
    step(1'b1, 1'b1);
    chk("t3_first_move", 8'(bus.moving), FIRST_MOVE);
    wait_idle("t3_first_idle", 100);
    chk("t3_first_remain", 8'(bus.remain), FIRST_RMN);
    step(1'b0, 1'b0);
    chk("t3_second_busy", 8'(bus.busy), 8'd1);
    chk("t3_second_move", 8'(bus.moving), SECOND_MOVE);
    wait_idle("t3_second_idle", 100);
    chk("t3_final_remain", 8'(bus.remain), 8'd5);

    // Exit on an empty garage is dropped silently.
    for (int i = 0; i < 4; i++) run_seq(1'b0, 1'b1, "t4_drain_idle");
    chk("t4_remain9", 8'(bus.remain), 8'd9);
    step(1'b0, 1'b1);
    chk("t4_busy", 8'(bus.busy), 8'd0);
    chk("t4_reject", 8'(bus.reject), 8'd0);
    step(1'b0, 1'b0);
    chk("t4_busy_later", 8'(bus.busy), 8'd0);
    chk("t4_reject_later", 8'(bus.reject), 8'd0);
    chk("t4_remain", 8'(bus.remain), 8'd9);

    // Extra requests during PASSING: one pending per direction.
    step(1'b1, 1'b0);
    wait_open("t5_open");
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("t5_still_open", 8'(bus.gate_open), 8'd1);
    rises = 0;
    for (int i = 0; i < 150; i++) begin
      pb = bus.busy;
      step(1'b0, 1'b0);
      if (!pb && bus.busy) rises++;
    end
    chk("t5_extra_seqs", 8'(rises), 8'd2);
    chk("t5_remain", 8'(bus.remain), 8'd8);
    chk("t5_idle", 8'(bus.busy), 8'd0);

    // Reset mid-PASSING with an entry pending.
    step(1'b1, 1'b0);
    wait_open("t6_open");
    step(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_remain", 8'(bus.remain), 8'd9);
    chk("t6_busy", 8'(bus.busy), 8'd0);
    chk("t6_moving", 8'(bus.moving), 8'd0);
    chk("t6_gate_open", 8'(bus.gate_open), 8'd0);
    chk("t6_full", 8'(bus.full), 8'd0);
    chk("t6_reject", 8'(bus.reject), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0);
      if (bus.busy) rises++;
    end
    chk("t6_no_pending", 8'(rises), 8'd0);
    chk("t6_remain_after", 8'(bus.remain), 8'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
